// File: rtl/load_unit_if.sv
// Load unit bus bundle: execute-stage request/response plus data-memory read port.
// The slave view belongs to the load unit; the master view drives it
// (the execute stage and memory side).
interface load_unit_if;
  logic        LdReq;
  logic [2:0]  LdFunct3;
  logic [31:0] LdAddr;
  logic        LdBusy;
  logic        MemRdReq;
  logic [31:0] MemAddr;
  logic        MemRdAck;
  logic [31:0] MemRdData;
  logic        LdValid;
  logic [31:0] LdData;
  logic        LdErr;
  logic [1:0]  LdErrCode;

  modport slave (
    input  LdReq, LdFunct3, LdAddr, MemRdAck, MemRdData,
    output LdBusy, MemRdReq, MemAddr, LdValid, LdData, LdErr, LdErrCode
  );

  modport master (
    output LdReq, LdFunct3, LdAddr, MemRdAck, MemRdData,
    input  LdBusy, MemRdReq, MemAddr, LdValid, LdData, LdErr, LdErrCode
  );
endinterface

// File: rtl/load_unit.sv
// Load unit: accepts one load at a time, checks it, reads one word from data
// memory, then aligns and extends the selected byte, halfword or word.
// Error requests (bad funct3, misaligned) never touch memory. A read that is
// not acknowledged within TIMEOUT wait cycles completes with a timeout error.
module load_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic         clk,
  input logic         rst,
  load_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ALIGN = 2'b01;
  localparam logic [1:0] E_TOUT  = 2'b10;
  localparam logic [1:0] E_FUNCT = 2'b11;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [7:0]  cnt;
  logic        illegal;
  logic        misal;

  // Pick the addressed lane and extend it according to the load type.
  function automatic logic [31:0] extract(input logic [2:0] f,
                                          input logic [1:0] a,
                                          input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'b0, b};
      3'b101:  extract = {16'b0, h};
      default: extract = d;
    endcase
  endfunction

  // Classify the request currently presented; illegal funct3 outranks misalignment.
  always_comb begin
    illegal = 1'b1;
    misal   = 1'b0;
    case (bus.LdFunct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: begin illegal = 1'b0; misal = bus.LdAddr[0];      end
      3'b010:         begin illegal = 1'b0; misal = |bus.LdAddr[1:0];   end
      default:        illegal = 1'b1;
    endcase
  end

  // Transaction FSM; every bus output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      funct3_q      <= '0;
      addr_q        <= '0;
      cnt           <= '0;
      bus.LdBusy    <= 1'b0;
      bus.MemRdReq  <= 1'b0;
      bus.MemAddr   <= '0;
      bus.LdValid   <= 1'b0;
      bus.LdData    <= '0;
      bus.LdErr     <= 1'b0;
      bus.LdErrCode <= E_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.LdReq) begin
            funct3_q   <= bus.LdFunct3;
            addr_q     <= bus.LdAddr;
            bus.LdBusy <= 1'b1;
            bus.LdData <= '0;
            if (illegal || misal) begin
              state         <= RESP;
              bus.LdValid   <= 1'b1;
              bus.LdErr     <= 1'b1;
              bus.LdErrCode <= illegal ? E_FUNCT : E_ALIGN;
            end else begin
              state        <= WAIT;
              cnt          <= '0;
              bus.MemRdReq <= 1'b1;
              bus.MemAddr  <= {bus.LdAddr[31:2], 2'b00};
            end
          end
        end
        WAIT: begin
          // Ack is checked first so an ack on the final allowed cycle still completes.
          if (bus.MemRdAck) begin
            state         <= RESP;
            bus.MemRdReq  <= 1'b0;
            bus.MemAddr   <= '0;
            bus.LdValid   <= 1'b1;
            bus.LdData    <= extract(funct3_q, addr_q[1:0], bus.MemRdData);
            bus.LdErr     <= 1'b0;
            bus.LdErrCode <= E_NONE;
          end else if (cnt == CNT_LAST) begin
            state         <= RESP;
            bus.MemRdReq  <= 1'b0;
            bus.MemAddr   <= '0;
            bus.LdValid   <= 1'b1;
            bus.LdData    <= '0;
            bus.LdErr     <= 1'b1;
            bus.LdErrCode <= E_TOUT;
          end else begin
            cnt         <= cnt + 8'd1;
            bus.MemAddr <= {addr_q[31:2], 2'b00};
          end
        end
        RESP: begin
          state         <= IDLE;
          bus.LdBusy    <= 1'b0;
          bus.LdValid   <= 1'b0;
          bus.LdData    <= '0;
          bus.LdErr     <= 1'b0;
          bus.LdErrCode <= E_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: directed and random loads against a reference model,
// with a queue-based scoreboard checked by an independent monitor.
module tb_load_unit;

  localparam int TO = 4;

  logic clk;
  logic rst;
  load_unit_if bus();

  load_unit #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic [1:0]  code;
    int          cyc;
    logic [15:0] reqs;
    logic [31:0] addr;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          ack_dly = 0;
  logic [31:0] mem_word = '0;
  bit          force_ack = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ctrl"}, {bus.LdBusy, bus.MemRdReq, bus.LdValid, bus.LdErr, bus.LdErrCode}, 64'd0);
    chk({nm, "_data"}, {bus.MemAddr, bus.LdData}, 64'd0);
  endtask

  // Reference model: result and latency derived from the load rules directly.
  function automatic exp_t model(input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] d, input int dly, output int lat);
    exp_t e;
    int sz;
    logic [31:0] sh;
    sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    e.data = 0; e.err = 1; e.code = 0; e.reqs = 0;
    e.addr = a & 32'hFFFF_FFFC;
    if (f == 3'd3 || f >= 3'd6) begin
      e.code = 2'b11; lat = 0;
    end else if ((a % sz) != 0) begin
      e.code = 2'b01; lat = 0;
    end else if (dly >= TO) begin
      e.code = 2'b10; lat = TO; e.reqs = 16'(TO);
    end else begin
      e.err = 0; lat = dly + 1; e.reqs = 16'(dly + 1);
      sh = d >> (8 * a[1:0]);
      if (sz == 1) begin
        e.data = sh & 32'hFF;
        if (!f[2] && e.data[7]) e.data = e.data | 32'hFFFF_FF00;
      end else if (sz == 2) begin
        e.data = sh & 32'hFFFF;
        if (!f[2] && e.data[15]) e.data = e.data | 32'hFFFF_0000;
      end else begin
        e.data = d;
      end
    end
    return e;
  endfunction

  // Edge counter used to check completion latency.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: acks on the chosen wait cycle, random noise outside WAIT.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.MemRdAck = 1'b0;
    bus.MemRdData = '0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        bus.MemRdAck = 1'b1; bus.MemRdData = $urandom; wcnt = 0;
      end else if (bus.MemRdReq) begin
        bus.MemRdAck  = (wcnt == ack_dly);
        bus.MemRdData = (wcnt == ack_dly) ? mem_word : $urandom;
        wcnt++;
      end else begin
        wcnt = 0;
        bus.MemRdAck = 1'($urandom_range(0, 1));
        bus.MemRdData = $urandom;
      end
    end
  end

  // Monitor: tracks the memory request, pops the scoreboard on each completion.
  initial begin
    logic [15:0] req_cnt;
    logic        addr_bad;
    exp_t        e;
    req_cnt = 0; addr_bad = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_cnt = 0; addr_bad = 0;
      end else begin
        if (bus.MemRdReq) begin
          req_cnt++;
          if (q.size() > 0 && bus.MemAddr !== q[0].addr) addr_bad = 1;
        end
        if (bus.LdValid) begin
          if (q.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
          else begin
            e = q.pop_front();
            chk("result{err,code,data}", {bus.LdErr, bus.LdErrCode, bus.LdData},
                {e.err, e.code, e.data});
            chk("timing{cyc,reqs,addrbad}", {cyc, req_cnt, addr_bad}, {e.cyc, e.reqs, 1'b0});
          end
          req_cnt = 0; addr_bad = 0;
        end
      end
    end
  end

  // One load, starting at a negedge with the unit idle; ends at the next idle negedge.
  task automatic do_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         input int dly, input bit hold);
    exp_t e;
    int   lat;
    bit   busy_ok, seen;
    e = model(f, a, d, dly, lat);
    e.cyc = cyc + 1 + lat;
    q.push_back(e);
    mem_word = d; ack_dly = dly;
    bus.LdReq = 1'b1; bus.LdFunct3 = f; bus.LdAddr = a;
    @(posedge clk);
    busy_ok = 1; seen = 0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (!bus.LdBusy) busy_ok = 0;
      bus.LdReq = hold; bus.LdFunct3 = 3'($urandom); bus.LdAddr = $urandom;
      if (bus.LdValid) seen = 1;
    end
    chk("completion", 64'(seen), 64'd1);
    chk("busy_during", 64'(busy_ok), 64'd1);
    @(negedge clk);
    chk("busy_idle", 64'(bus.LdBusy), 64'd0);
  endtask

  // Abort a load mid-WAIT with reset, then offer a late ack.
  task automatic reset_mid_wait();
    int vcnt;
    mem_word = $urandom; ack_dly = 1000;
    bus.LdReq = 1'b1; bus.LdFunct3 = 3'b010; bus.LdAddr = 32'h0000_1230;
    @(posedge clk);
    @(negedge clk);
    bus.LdReq = 1'b0;
    chk("wait_memreq", 64'(bus.MemRdReq), 64'd1);
    #2 rst = 1'b1;
    #1 chk_zero("reset_async");
    @(negedge clk);
    #2 rst = 1'b0;
    force_ack = 1'b1;
    vcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.LdValid) vcnt++;
    end
    force_ack = 1'b0;
    chk("no_valid_after_reset", 64'(vcnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [2:0] legal[5];
    logic [2:0] f;
    logic [31:0] a;
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    rst = 1'b1;
    bus.LdReq = 1'b0; bus.LdFunct3 = '0; bus.LdAddr = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    #2 rst = 1'b0;
    @(negedge clk);

    do_load(3'b000, 32'h0000_1003, 32'h8000_0000, 0, 0);
    do_load(3'b100, 32'h0000_1003, 32'h8000_0000, 0, 0);
    do_load(3'b101, 32'h0000_0002, 32'h8001_1234, 0, 0);
    do_load(3'b001, 32'h0000_0002, 32'h8001_1234, 0, 0);
    do_load(3'b010, 32'h0000_0001, 32'h1234_5678, 0, 0);
    do_load(3'b011, 32'h0000_0000, 32'h1234_5678, 0, 0);
    do_load(3'b010, 32'h0000_0040, 32'hCAFE_F00D, 1000, 0);
    do_load(3'b010, 32'h0000_0044, 32'hDEAD_BEEF, TO - 1, 1);
    do_load(3'b000, 32'h0000_0005, 32'h0000_7F00, 2, 1);
    do_load(3'b001, 32'h0000_0003, 32'h0000_7F00, 0, 0);

    reset_mid_wait();
    do_load(3'b010, 32'h0000_2000, 32'h0BAD_CAFE, 0, 0);

    for (int i = 0; i < 60; i++) begin
      f = ($urandom % 4 == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      a = $urandom;
      do_load(f, a, $urandom, $urandom_range(0, TO + 1), (i != 59) && ($urandom % 2 == 1));
    end

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum WAIT-state cycles without MemRdAck before a timeout error; legal range 1..255.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port LdReq  input  1  load request from execute stage.
REQ-005 SHALL have port LdFunct3  input  3  load type (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-006 SHALL have port LdAddr  input  32  byte address of the load.
REQ-007 SHALL have port LdBusy  output  1  high when a request cannot be accepted.
REQ-008 SHALL have port MemRdReq  output  1  read request to data memory.
REQ-009 SHALL have port MemAddr  output  32  word-aligned read address.
REQ-010 SHALL have port MemRdAck  input  1  memory read acknowledge; MemRdData valid in the same cycle.
REQ-011 SHALL have port MemRdData  input  32  little-endian read word.
REQ-012 SHALL have port LdValid  output  1  one-cycle completion pulse.
REQ-013 SHALL have port LdData  output  32  aligned, extended load result.
REQ-014 SHALL have port LdErr  output  1  completion carries an error; qualified by LdValid.
REQ-015 SHALL have port LdErrCode  output  2  00 none, 01 misaligned, 10 timeout, 11 illegal funct3.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE with LdReq=1, SHALL capture LdFunct3 and LdAddr into internal registers on the same edge.
REQ-018 SHALL classify each accepted request, in priority order: illegal funct3 (any code not listed in REQ-005), then misaligned (LH/LHU with addr[0]=1; LW with addr[1:0]!=00), then legal.
REQ-019 Illegal and misaligned requests SHALL go IDLE->RESP without asserting MemRdReq; LdErr=1, LdErrCode as in REQ-015, LdData=0.
REQ-020 Legal requests SHALL go IDLE->WAIT; in WAIT, MemRdReq=1 and MemAddr={addr[31:2],2'b00}, held stable until MemRdAck is sampled high.
REQ-021 In WAIT, on the edge where MemRdAck=1, SHALL register the extracted result and go to RESP.
REQ-022 SHALL maintain a WAIT-cycle counter, cleared on entry to WAIT.
REQ-023 If the counter reaches TIMEOUT with MemRdAck=0, SHALL go to RESP with LdErr=1, LdErrCode=10, LdData=0.
REQ-024 If MemRdAck=1 arrives in the same cycle the timeout would fire, SHALL complete normally (ack wins).
REQ-025 In RESP, SHALL assert LdValid for exactly one cycle, then return to IDLE.
REQ-026 LdData, LdErr and LdErrCode SHALL be stable while LdValid=1.
REQ-027 Byte extraction SHALL select MemRdData[8*a+7:8*a], where a=addr[1:0].
REQ-028 Halfword extraction SHALL select MemRdData[31:16] when addr[1]=1, else MemRdData[15:0].
REQ-029 LB/LH results SHALL be sign-extended to 32 bits; LBU/LHU results zero-extended; LW passed unchanged.
REQ-030 LdBusy SHALL be 1 in WAIT and RESP, 0 in IDLE.
REQ-031 LdReq SHALL be ignored outside IDLE; no queuing.
REQ-032 Minimum latency SHALL be 2 edges: request accepted at edge N, ack at edge N+1, LdValid high during cycle after edge N+1. Error requests: LdValid high in cycle after edge N.
REQ-033 MemRdAck SHALL be ignored outside WAIT.

Reset
REQ-034 On rst=1, SHALL asynchronously enter IDLE, clear the counter and captured registers, and force MemRdReq=0, MemAddr=0, LdValid=0, LdData=0, LdErr=0, LdErrCode=00, LdBusy=0.
REQ-035 Reset asserted during WAIT or RESP SHALL abort the transaction with no LdValid pulse; a late MemRdAck after reset release SHALL be ignored.

Verification
REQ-036 LB, LdAddr=0x00001003, MemRdData=0x80000000 with ack in first WAIT cycle -> LdData=0xFFFFFF80, LdErr=0, LdValid for one cycle, 2 edges after request.
REQ-037 LBU, same address and data -> LdData=0x00000080; LHU at 0x00000002, data 0x80011234 -> LdData=0x00008001; LH at same address and data -> LdData=0xFFFF8001.
REQ-038 LW at 0x00000001 -> MemRdReq never asserted; LdValid next cycle with LdErr=1, LdErrCode=01, LdData=0; funct3=011 -> LdErrCode=11.
REQ-039 TIMEOUT=4, legal LW, MemRdAck held 0 -> MemRdReq high for 4 cycles, then LdValid with LdErrCode=10; repeat with ack on 4th WAIT cycle -> normal data, LdErr=0.
REQ-040 rst pulsed during WAIT -> all outputs 0 immediately; ack driven after release -> no LdValid; next LdReq is accepted normally.
REQ-041 LdReq held high across back-to-back loads -> second request accepted only in the IDLE cycle after RESP; LdBusy=1 throughout each transaction.
